fft4_output_reorder: RTL and testbench
======================================

Name: fft4_output_reorder

Overview:
- Sits directly downstream of the 4-point pipelined FFT stage.
- Consumes the stage's y_r/y_im output stream, which arrives in bit-reversed bin order.
- Buffers each frame in a two-bank ping-pong memory and re-emits it in natural bin order with a valid/ready handshake.
- Flags frames lost to downstream backpressure, because the FFT stage cannot be stalled.

Parameters:
- DW, 8, width of each real/imag component (matches the FFT stage's n/2 output width).
- LOG2N, 2, log2 of points per frame; N = 2**LOG2N = 4.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  synchronous active-high reset.
- in_valid  input  1  FFT stage output sample valid this cycle.
- in_re  input  DW  real part from FFT stage (y_r).
- in_im  input  DW  imag part from FFT stage (y_im).
- in_ready  output  1  write bank has space; informational only, the FFT stage ignores it.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts the output sample.
- out_re  output  DW  real part, natural order.
- out_im  output  DW  imag part, natural order.
- out_idx  output  LOG2N  natural bin index of the current output.
- out_last  output  1  high with bin N-1 of each frame.
- overflow  output  1  sticky flag: an input sample was dropped.

Behaviour:
- Reset: clear is sampled on the rising clk edge. Every register is forced to 0: wr_cnt, wr_bank, rd_cnt, rd_bank, full[1:0], out_valid, out_re, out_im, out_idx, out_last and overflow. in_ready is therefore 1 after reset. Any partial frame is discarded. clear takes priority over all other activity in the same cycle.
- Storage: mem[2][N] of {re, im}, 2*DW bits per entry. Memory contents are not reset.
- Write side:
  - A sample is accepted when in_valid=1 and full[wr_bank]=0. It is stored at mem[wr_bank][bitrev(wr_cnt)], where bitrev reverses all LOG2N bits. wr_cnt then increments.
  - When the sample written has wr_cnt=N-1: wr_cnt wraps to 0, full[wr_bank] is set, and wr_bank toggles.
- Drop: when in_valid=1 and full[wr_bank]=1, the sample is discarded and overflow is set. overflow stays set until clear. wr_cnt does not advance.
- in_ready is combinational: in_ready = ~full[wr_bank].
- Read side (states IDLE, DRAIN):
  - IDLE: when full[rd_bank]=1, go to DRAIN.
  - DRAIN: the output register loads whenever out_valid=0 or (out_valid & out_ready)=1. It loads out_re and out_im from mem[rd_bank][rd_cnt], sets out_idx=rd_cnt, sets out_last=(rd_cnt==N-1), sets out_valid=1, and increments rd_cnt.
  - On loading rd_cnt=N-1: clear full[rd_bank], toggle rd_bank, wrap rd_cnt to 0, and return to IDLE. If the other bank is already full, go straight back into DRAIN with no bubble.
  - In IDLE, or after the last sample, if the handshake completes with no new load, out_valid drops to 0.
- Latency: the last sample of a frame is accepted at edge E0. out_valid=1 with out_idx=0 is registered at edge E0+1, then out_valid is high in the following cycle.
- Throughput: one sample per cycle while out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out_re, out_im, out_idx and out_last hold their values.
- Simultaneous events: the writer sets full on one bank while the reader clears full on the other. Both update in the same edge without conflict. The same bank can never be set and cleared in the same cycle.
- Reading and writing the same entry in one cycle cannot occur, since a bank is read only while it is full.
- Arithmetic: data passes through unchanged. No saturation or scaling is applied.

Test Plan:
- Basic reorder: after reset, drive 4 consecutive in_valid cycles with in_re=0x10,0x11,0x12,0x13 and in_im=0xA0..0xA3, with out_ready=1. Expect out_re=0x10,0x12,0x11,0x13 and out_im=0xA0,0xA2,0xA1,0xA3 on consecutive cycles, out_idx=0,1,2,3, out_last only on idx 3, and the first out_valid one cycle after the 4th input.
- Back-to-back frames: send 3 frames continuously (12 cycles of in_valid), out_ready=1. Expect 12 outputs with no gaps after the first, in correct per-frame order, and overflow=0.
- Backpressure: hold out_ready=0 for 6 cycles during the first frame's output. Expect the data held stable and out_valid=1 throughout, then 0x12, 0x11, 0x13 emitted after release with no loss.
- Overflow: out_ready=0 permanently, send 3 full frames. Expect in_ready=0 after frame 2 and all 4 samples of frame 3 dropped. overflow=1 stays set. Releasing out_ready yields exactly frames 1 and 2.
- Reset mid-operation: assert clear after 2 samples of a frame and while out_valid=1. Expect all outputs 0 the next cycle and overflow=0. A fresh 4-sample frame then produces correct order starting at idx 0.
- Boundary: a single in_valid gap between samples 1 and 2 of a frame still completes the frame. out_last asserts exactly once per frame.

Source files
------------

// File: rtl/fft4_output_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft4_output_reorder
// Purpose  : Ping-pong buffer that turns the bit-reversed FFT output stream
//            into natural bin order with a valid/ready output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fft4_output_reorder #(
    parameter int DW    = 8,
    parameter int LOG2N = 2
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_re,
    input  logic [DW-1:0]    in_im,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
    output logic             overflow
);
    localparam int               c_N        = 1 << LOG2N;
    localparam logic [LOG2N-1:0] c_LAST_IDX = LOG2N'(c_N - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [2*DW-1:0]  r_mem [2][c_N];
    logic [LOG2N-1:0] r_wr_cnt;
    logic             r_wr_bank;
    logic [LOG2N-1:0] r_rd_cnt;
    logic             r_rd_bank;
    logic [1:0]       r_full;
    state_t           r_state;
    logic             r_out_valid;
    logic [DW-1:0]    r_out_re;
    logic [DW-1:0]    r_out_im;
    logic [LOG2N-1:0] r_out_idx;
    logic             r_out_last;
    logic             r_overflow;

    logic             w_wr_full;
    logic             w_accept;
    logic             w_drop;
    logic             w_wr_last;
    logic             w_can_load;
    logic             w_load;
    logic             w_rd_last;
    logic [1:0]       w_set;
    logic [1:0]       w_clr;
    logic [1:0]       w_full_nxt;
    logic [2*DW-1:0]  w_rd_data;

    assign w_wr_full  = r_full[r_wr_bank];
    assign w_accept   = in_valid & ~w_wr_full;
    assign w_drop     = in_valid & w_wr_full;
    assign w_wr_last  = w_accept & (r_wr_cnt == c_LAST_IDX);

    // IDLE loads the first entry in the same edge it sees a full bank so the
    // first output appears one cycle after the frame completes.
    assign w_can_load = ~r_out_valid | out_ready;
    assign w_load     = w_can_load & ((r_state == S_DRAIN) | r_full[r_rd_bank]);
    assign w_rd_last  = w_load & (r_rd_cnt == c_LAST_IDX);

    // Writer and reader always own different banks while both are active.
    assign w_set      = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr      = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_full_nxt = (r_full | w_set) & ~w_clr;
    assign w_rd_data  = r_mem[r_rd_bank][r_rd_cnt];

    always_ff @(posedge clk) begin
        if (w_accept && !clear) begin
            r_mem[r_wr_bank][f_bitrev(r_wr_cnt)] <= {in_re, in_im};
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_wr_cnt    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_rd_bank   <= 1'b0;
            r_full      <= 2'b00;
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rd_bank] && !w_rd_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_rd_last) begin
                        r_state <= w_full_nxt[~r_rd_bank] ? S_DRAIN : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_re    <= w_rd_data[2*DW-1:DW];
                r_out_im    <= w_rd_data[DW-1:0];
                r_out_idx   <= r_rd_cnt;
                r_out_last  <= (r_rd_cnt == c_LAST_IDX);
                r_rd_cnt    <= r_rd_cnt + 1'b1;
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = ~w_wr_full;
    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fft4_output_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft4_output_reorder
// Purpose  : Directed self-checking bench for fft4_output_reorder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft4_output_reorder;
    localparam int c_DW    = 8;
    localparam int c_LOG2N = 2;

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic             in_valid = 1'b0;
    logic [c_DW-1:0]  in_re = '0;
    logic [c_DW-1:0]  in_im = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [c_DW-1:0]  out_re;
    logic [c_DW-1:0]  out_im;
    logic [c_LOG2N-1:0] out_idx;
    logic             out_last;
    logic             overflow;

    typedef struct {
        logic [7:0] re;
        logic [7:0] im;
        logic [1:0] idx;
        logic       last;
        int         cyc;
    } rec_t;

    rec_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   ord[4]   = '{0, 2, 1, 3};

    fft4_output_reorder #(.DW(c_DW), .LOG2N(c_LOG2N)) u_dut (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each negedge with valid&ready is exactly one transfer at the next edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q.push_back('{out_re, out_im, out_idx, out_last, cyc});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] re, input logic [7:0] im);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b_re, input logic [7:0] b_im);
        for (int k = 0; k < 4; k++) begin
            send(b_re + 8'(k), b_im + 8'(k));
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Frame f carries inputs base+4f+k; natural order pulls them as k = 0,2,1,3.
    task automatic check_frames(input string tag, input logic [7:0] b_re, input logic [7:0] b_im,
                                input int nfr, input bit gapless);
        check_eq({tag, "_count"}, q.size(), nfr * 4);
        for (int i = 0; i < nfr * 4 && i < q.size(); i++) begin
            int f = i / 4;
            int k = i % 4;
            check_eq({tag, "_re"},   q[i].re,   b_re + 8'(4 * f + ord[k]));
            check_eq({tag, "_im"},   q[i].im,   b_im + 8'(4 * f + ord[k]));
            check_eq({tag, "_idx"},  q[i].idx,  k);
            check_eq({tag, "_last"}, q[i].last, (k == 3));
            if (gapless && i > 0) begin
                check_eq({tag, "_gap"}, q[i].cyc, q[i-1].cyc + 1);
            end
        end
        q.delete();
    endtask

    initial begin
        int n_last;

        // Reset state
        step(2);
        clear = 1'b0;
        check_eq("rst_valid",    out_valid, 0);
        check_eq("rst_in_ready", in_ready,  1);
        check_eq("rst_overflow", overflow,  0);
        check_eq("rst_re",       out_re,    0);
        check_eq("rst_im",       out_im,    0);
        check_eq("rst_idx",      out_idx,   0);
        check_eq("rst_last",     out_last,  0);

        // Basic reorder and first-output latency
        out_ready = 1'b1;
        q.delete();
        send_frame(8'h10, 8'hA0);
        check_eq("lat_not_yet", out_valid, 0);
        step();
        check_eq("lat_valid", out_valid, 1);
        check_eq("lat_idx",   out_idx,   0);
        check_eq("lat_re",    out_re,    8'h10);
        step(5);
        check_frames("basic", 8'h10, 8'hA0, 1, 1'b1);

        // Back-to-back frames
        for (int f = 0; f < 3; f++) begin
            send_frame(8'h20 + 8'(4 * f), 8'hB0 + 8'(4 * f));
        end
        step(6);
        check_frames("b2b", 8'h20, 8'hB0, 3, 1'b1);
        check_eq("b2b_overflow", overflow, 0);

        // Backpressure hold
        do_clear();
        q.delete();
        send_frame(8'h10, 8'hA0);
        step(2);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_re",    out_re,    8'h12);
            check_eq("bp_im",    out_im,    8'hA2);
            check_eq("bp_idx",   out_idx,   1);
            check_eq("bp_last",  out_last,  0);
        end
        out_ready = 1'b1;
        step(6);
        check_frames("bp", 8'h10, 8'hA0, 1, 1'b0);

        // Overflow: two frames buffered, third dropped
        do_clear();
        out_ready = 1'b0;
        q.delete();
        send_frame(8'h40, 8'hC0);
        send_frame(8'h44, 8'hC4);
        check_eq("ovf_in_ready", in_ready, 0);
        check_eq("ovf_pre",      overflow, 0);
        send_frame(8'h48, 8'hC8);
        check_eq("ovf_set", overflow, 1);
        out_ready = 1'b1;
        step(12);
        check_frames("ovf", 8'h40, 8'hC0, 2, 1'b1);
        check_eq("ovf_sticky",      overflow,  1);
        check_eq("ovf_in_ready_ok", in_ready,  1);
        check_eq("ovf_drained",     out_valid, 0);

        // Reset mid-operation
        do_clear();
        send_frame(8'h70, 8'hD0);
        out_ready = 1'b0;
        send(8'h90, 8'hE0);
        send(8'h91, 8'hE1);
        check_eq("mid_valid_before", out_valid, 1);
        do_clear();
        check_eq("mid_valid",    out_valid, 0);
        check_eq("mid_re",       out_re,    0);
        check_eq("mid_im",       out_im,    0);
        check_eq("mid_idx",      out_idx,   0);
        check_eq("mid_last",     out_last,  0);
        check_eq("mid_overflow", overflow,  0);
        check_eq("mid_in_ready", in_ready,  1);
        out_ready = 1'b1;
        q.delete();
        send_frame(8'h80, 8'hF0);
        step(6);
        check_frames("mid", 8'h80, 8'hF0, 1, 1'b1);

        // Single-cycle input gap inside a frame
        send(8'h30, 8'h50);
        send(8'h31, 8'h51);
        step();
        send(8'h32, 8'h52);
        send(8'h33, 8'h53);
        step(6);
        n_last = 0;
        foreach (q[i]) begin
            if (q[i].last) n_last++;
        end
        check_eq("gap_last_count", n_last, 1);
        check_frames("gap", 8'h30, 8'h50, 1, 1'b1);
        check_eq("gap_overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
